// File: rtl/hamming_secded_stream_decoder.sv
// Pipelined SECDED Hamming decoder: S1 registers codeword + syndrome/parity,
// S2 registers corrected data and error classification. Saturating error counters.
module hamming_secded_stream_decoder #(
  parameter int unsigned R     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2**R-1:0]       in_code,
  input  logic                  correct_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**R-R-2:0]     out_data,
  output logic                  out_err_single,
  output logic                  out_err_double,
  output logic [R-1:0]          out_err_pos,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      corr_count,
  output logic [CNT_W-1:0]      uncorr_count
);

  localparam int unsigned N = 2**R;
  localparam int unsigned K = N - R - 1;

  function automatic logic [R-1:0] syndrome(input logic [N-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int unsigned j = 1; j < N; j++) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (j[i]) s[i] = s[i] ^ c[j];
      end
    end
    return s;
  endfunction

  // Data bits live at every non-power-of-two index above 0, in ascending order.
  function automatic logic [K-1:0] extract(input logic [N-1:0] c);
    logic [K-1:0] d;
    int unsigned  k;
    d = '0;
    k = 0;
    for (int unsigned j = 1; j < N; j++) begin
      if ((j & (j - 1)) != 0) begin
        d[k] = c[j];
        k++;
      end
    end
    return d;
  endfunction

  logic         adv;

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_code_q,  s1_code_d;
  logic [R-1:0] s1_syn_q,   s1_syn_d;
  logic         s1_par_q,   s1_par_d;
  logic         s1_corr_q,  s1_corr_d;

  logic         out_valid_q,  out_valid_d;
  logic [K-1:0] out_data_q,   out_data_d;
  logic         err_single_q, err_single_d;
  logic         err_double_q, err_double_d;
  logic [R-1:0] err_pos_q,    err_pos_d;

  logic [CNT_W-1:0] corr_count_q,   corr_count_d;
  logic [CNT_W-1:0] uncorr_count_q, uncorr_count_d;

  logic [N-1:0] fix_mask;
  logic         s1_single, s1_double;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign s1_single = s1_par_q;
  assign s1_double = (s1_syn_q != '0) && !s1_par_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    s1_corr_d  = s1_corr_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_code_d  = in_code;
      s1_syn_d   = syndrome(in_code);
      s1_par_d   = ^in_code;
      s1_corr_d  = correct_en;
    end
  end

  always_comb begin
    fix_mask = '0;
    if (s1_single && s1_corr_q) fix_mask[s1_syn_q] = 1'b1;

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    err_pos_d    = err_pos_q;
    if (adv) begin
      out_valid_d  = s1_valid_q;
      out_data_d   = extract(s1_code_q ^ fix_mask);
      err_single_d = s1_single;
      err_double_d = s1_double;
      err_pos_d    = s1_syn_q;
    end
  end

  // Clear takes priority over an increment landing on the same edge.
  always_comb begin
    corr_count_d   = corr_count_q;
    uncorr_count_d = uncorr_count_q;
    if (cnt_clr) begin
      corr_count_d   = '0;
      uncorr_count_d = '0;
    end else if (adv && s1_valid_q) begin
      if (s1_single && (corr_count_q != '1))
        corr_count_d = corr_count_q + CNT_W'(1);
      if (s1_double && (uncorr_count_q != '1))
        uncorr_count_d = uncorr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_code_q      <= '0;
      s1_syn_q       <= '0;
      s1_par_q       <= 1'b0;
      s1_corr_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      err_single_q   <= 1'b0;
      err_double_q   <= 1'b0;
      err_pos_q      <= '0;
      corr_count_q   <= '0;
      uncorr_count_q <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_code_q      <= s1_code_d;
      s1_syn_q       <= s1_syn_d;
      s1_par_q       <= s1_par_d;
      s1_corr_q      <= s1_corr_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      err_single_q   <= err_single_d;
      err_double_q   <= err_double_d;
      err_pos_q      <= err_pos_d;
      corr_count_q   <= corr_count_d;
      uncorr_count_q <= uncorr_count_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_err_single = err_single_q;
  assign out_err_double = err_double_q;
  assign out_err_pos    = err_pos_q;
  assign corr_count     = corr_count_q;
  assign uncorr_count   = uncorr_count_q;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Directed and randomized back-pressure checks of the SECDED stream decoder
// against an index-XOR syndrome reference model and an in-order scoreboard.
module tb_hamming_secded_stream_decoder;

  localparam int unsigned R  = 4;
  localparam int unsigned N  = 16;
  localparam int unsigned K  = 11;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_code = '0;
  logic          correct_en = 1'b1;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [K-1:0]  out_data;
  logic          out_err_single;
  logic          out_err_double;
  logic [R-1:0]  out_err_pos;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [K-1:0] data;
    logic         single;
    logic         dbl;
    logic [R-1:0] pos;
  } exp_t;

  exp_t q[$];
  int   mc, mu, transfers;
  logic head_counted, stalled_prev;
  exp_t snap;
  logic snap_valid;

  hamming_secded_stream_decoder #(.R(R), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .correct_en(correct_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_single(out_err_single), .out_err_double(out_err_double), .out_err_pos(out_err_pos),
    .cnt_clr(cnt_clr), .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: syndrome is the XOR of the indices of all set bits.
  function automatic exp_t model(input logic [N-1:0] c_in, input logic ce);
    exp_t         e;
    logic [N-1:0] c;
    int unsigned  s;
    int unsigned  k;
    logic         par;
    c = c_in;
    s = 0;
    k = 0;
    par = ($countones(c) % 2) == 1;
    for (int unsigned j = 1; j < N; j++) if (c[j]) s = s ^ j;
    e.single = par;
    e.dbl    = (s != 0) && !par;
    e.pos    = s[R-1:0];
    if (par && ce) c[s] = ~c[s];
    e.data = '0;
    for (int unsigned j = 1; j < N; j++) begin
      if ((j & (j - 1)) != 0) begin
        e.data[k] = c[j];
        k++;
      end
    end
    return e;
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [N-1:0] c;
    int unsigned  k;
    logic         b;
    c = '0;
    k = 0;
    for (int unsigned j = 1; j < N; j++) begin
      if ((j & (j - 1)) != 0) begin
        c[j] = d[k];
        k++;
      end
    end
    for (int unsigned p = 1; p < N; p = p * 2) begin
      b = 1'b0;
      for (int unsigned j = 1; j < N; j++) if (((j & p) != 0) && (j != p)) b = b ^ c[j];
      c[p] = b;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic directed(input string tag, input logic [N-1:0] code, input logic ce,
                          input logic [K-1:0] ed, input logic es, input logic edb,
                          input logic [R-1:0] ep, input int unsigned ecorr, input int unsigned eunc);
    @(negedge clk);
    in_valid = 1'b1; in_code = code; correct_en = ce; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"},  32'(out_valid), 32'd1);
    chk({tag, "_data"},   32'(out_data), 32'(ed));
    chk({tag, "_single"}, 32'(out_err_single), 32'(es));
    chk({tag, "_double"}, 32'(out_err_double), 32'(edb));
    chk({tag, "_pos"},    32'(out_err_pos), 32'(ep));
    chk({tag, "_corr"},   32'(corr_count), ecorr);
    chk({tag, "_uncorr"}, 32'(uncorr_count), eunc);
  endtask

  task automatic drive_random_word();
    logic [K-1:0] d;
    int unsigned  nflip, b1, b2;
    d = K'($urandom);
    in_code = encode(d);
    nflip = $urandom_range(0, 2);
    b1 = $urandom_range(0, N - 1);
    if (nflip >= 1) in_code[b1] = ~in_code[b1];
    if (nflip == 2) begin
      b2 = (b1 + $urandom_range(1, N - 1)) % N;
      in_code[b2] = ~in_code[b2];
    end
    correct_en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic random_phase(input int ncyc, input int feed_cyc);
    exp_t h;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      if (stalled_prev) begin
        chk("stall_valid",  32'(out_valid), 32'(snap_valid));
        chk("stall_data",   32'(out_data), 32'(snap.data));
        chk("stall_single", 32'(out_err_single), 32'(snap.single));
        chk("stall_double", 32'(out_err_double), 32'(snap.dbl));
        chk("stall_pos",    32'(out_err_pos), 32'(snap.pos));
      end
      if (out_valid && !head_counted) begin
        if (q.size() == 0) chk("rnd_spurious_word", 32'd1, 32'd0);
        else begin
          h = q[0];
          if (h.single) mc = sat(mc + 1);
          if (h.dbl)    mu = sat(mu + 1);
        end
        head_counted = 1'b1;
      end
      chk("rnd_corr_count",   32'(corr_count), 32'(mc));
      chk("rnd_uncorr_count", 32'(uncorr_count), 32'(mu));

      out_ready = ($urandom_range(0, 99) < 60);
      in_valid  = (cyc < feed_cyc) && ($urandom_range(0, 99) < 70);
      drive_random_word();
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_pop_empty", 32'd1, 32'd0);
        else begin
          h = q.pop_front();
          chk("rnd_data",   32'(out_data), 32'(h.data));
          chk("rnd_single", 32'(out_err_single), 32'(h.single));
          chk("rnd_double", 32'(out_err_double), 32'(h.dbl));
          chk("rnd_pos",    32'(out_err_pos), 32'(h.pos));
          transfers++;
        end
        head_counted = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(in_code, correct_en));
      stalled_prev = out_valid && !out_ready;
      snap_valid   = out_valid;
      snap.data    = out_data;
      snap.single  = out_err_single;
      snap.dbl     = out_err_double;
      snap.pos     = out_err_pos;
    end
  endtask

  task automatic clear_model();
    q.delete();
    mc = 0; mu = 0;
    head_counted = 1'b0;
    stalled_prev = 1'b0;
  endtask

  initial begin
    clear_model();
    transfers = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data), 32'd0);
    chk("rst_single",    32'(out_err_single), 32'd0);
    chk("rst_double",    32'(out_err_double), 32'd0);
    chk("rst_pos",       32'(out_err_pos), 32'd0);
    chk("rst_corr",      32'(corr_count), 32'd0);
    chk("rst_uncorr",    32'(uncorr_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Spec vectors
    directed("clean",     16'hB44B, 1'b1, 11'h5A5, 1'b0, 1'b0, 4'd0,  0, 0);
    directed("single_b6", 16'hB40B, 1'b1, 11'h5A5, 1'b1, 1'b0, 4'd6,  1, 0);
    directed("single_b0", 16'hB44A, 1'b1, 11'h5A5, 1'b1, 1'b0, 4'd0,  2, 0);
    directed("double",    16'hB60B, 1'b1, 11'h5B1, 1'b0, 1'b1, 4'd15, 2, 1);
    directed("detect",    16'hB40B, 1'b0, 11'h5A1, 1'b1, 1'b0, 4'd6,  3, 1);

    // Saturation of 2-bit counter
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    chk("clr_corr",   32'(corr_count), 32'd0);
    chk("clr_uncorr", 32'(uncorr_count), 32'd0);
    for (int i = 1; i <= 5; i++)
      directed($sformatf("sat%0d", i), 16'hB40B, 1'b1, 11'h5A5, 1'b1, 1'b0, 4'd6, sat(i), 0);

    // Clear on the same edge as an increment
    @(negedge clk);
    in_valid = 1'b1; in_code = 16'hB40B; correct_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_race_valid",  32'(out_valid), 32'd1);
    chk("clr_race_single", 32'(out_err_single), 32'd1);
    chk("clr_race_corr",   32'(corr_count), 32'd0);

    // Drain, then random stream with back-pressure
    repeat (2) @(negedge clk);
    chk("pre_rnd_idle_valid", 32'(out_valid), 32'd0);
    clear_model();
    random_phase(60, 60);

    // Reset with words in flight
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_valid",    32'(out_valid), 32'd0);
    chk("midrst_corr",     32'(corr_count), 32'd0);
    chk("midrst_uncorr",   32'(uncorr_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_ghost", 32'(out_valid), 32'd0);
    end
    clear_model();

    transfers = 0;
    random_phase(300, 240);
    chk("rnd_queue_drained", 32'(q.size()), 32'd0);
    chk("rnd_enough_words",  32'(transfers >= 8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
